ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter and sequencer for the single-port `ram` block, which has an asynchronous read and a shared tri-state data bus. Port 0 is the instruction-fetch requester and is read-only. Port 1 is the load/store requester. The block grants one access per cycle using round-robin priority and drives the RAM `addr`/`rdEn`/`wrEn`/`data` lines from registers. It inserts a bus-turnaround cycle whenever the data-bus direction changes, and returns registered read data to the winning port.

## Interface
Parameters (widths `AWIDTH`, `DWIDTH` come from `InstructionStruct`):
- `TURN_EN`, default 1: 1 inserts a one-cycle TURN bubble on a read↔write direction change; 0 disables it.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0`  in  1  port-0 read request (level).
- `addr0`  in  AWIDTH  port-0 address.
- `gnt0`  out  1  port-0 grant (combinational); a transfer occurs at the posedge where `req0 && gnt0`.
- `rvalid0`  out  1  one-cycle pulse; `rdata` holds port-0 read data.
- `req1`  in  1  port-1 request (level).
- `we1`  in  1  port-1 direction: 1 = write, 0 = read.
- `addr1`  in  AWIDTH  port-1 address.
- `wdata1`  in  DWIDTH  port-1 write data.
- `gnt1`  out  1  port-1 grant (combinational).
- `rvalid1`  out  1  one-cycle pulse; `rdata` holds port-1 read data.
- `rdata`  out  DWIDTH  registered read data, shared by both ports.
- `ram_addr`  out  AWIDTH  to RAM `addr`.
- `ram_rd_en`  out  1  to RAM `rdEn`.
- `ram_wr_en`  out  1  to RAM `wrEn`.
- `ram_data`  inout  DWIDTH  to RAM `data`.
  - Driven with the write data only while `ram_wr_en` = 1.
  - `'z` otherwise.

## Operation
- **States:** IDLE, READ, WRITE, TURN. The state register equals the access currently on the RAM pins.
- **Pick (round-robin):**
  - One requester pending: pick it.
  - Both pending: pick the port that did not win the previous grant.
  - `last_winner` resets to port 1, so port 0 wins the first tie.
  - The pick is computed regardless of masking; this guarantees no starvation.
- **Mask:** the grant to the picked port is suppressed when either:
  - state = READ and the pick is a write, or
  - state = WRITE and the pick is a read.
  - IDLE and TURN never mask.
  - With `TURN_EN` = 0, no masking is applied.
- `gntN` = pick is N && unmasked. At most one grant is high per cycle.
- **On an accepted transfer (posedge):**
  - Latch the address and write data into `ram_addr` and the write-data register.
  - Set `ram_rd_en`/`ram_wr_en` for the next cycle.
  - Record the port index in `last_winner` and in the response tag.
- **Transitions:**
  - IDLE/TURN → READ or WRITE on acceptance; otherwise → IDLE.
  - READ/WRITE → READ or WRITE on acceptance.
  - READ/WRITE → TURN if a request is pending but masked.
  - READ/WRITE → IDLE if no request is pending.
- **Read response:** `rdata` captures `ram_data` at the posedge ending the READ cycle. `rvalid[tag]` pulses for exactly the following cycle.
- **Writes:** no response. The RAM commits the write at the posedge ending the WRITE cycle.
- **Idle pins:** in IDLE and TURN, `ram_rd_en` = `ram_wr_en` = 0, `ram_data` = `'z`, and `ram_addr` holds its last value.
- **Simultaneous events:** a write and a read to the same address are never concurrent; the bus is single-access. A read issued after a write returns the new data.

## Timing
- **Reset values (async, immediate on `rst_n` = 0):**
  - state = IDLE.
  - `ram_rd_en` = `ram_wr_en` = 0, `ram_addr` = 0, `ram_data` = `'z`.
  - `rdata` = 0, `rvalid0` = `rvalid1` = 0.
  - `last_winner` = 1.
- **Reset mid-operation:** an in-flight WRITE is aborted, because `wr_en` falls before the next edge, so the memory is unchanged. A pending `rvalid` is cancelled.
- **Read latency:** accept at edge k → READ in cycle k+1 → `rvalid` in cycle k+2.
- **Throughput:** one access per cycle for same-direction streams.
- **Direction change with `TURN_EN` = 1:** exactly one TURN cycle (bus `'z`); the new direction can be granted during TURN.
- **Handshake:** requesters hold `req`/`addr`/`we1`/`wdata1` stable until the cycle `gnt` is high. Dropping `req` before the grant is legal (abandons the request).

## Structure
- Add to `InstructionStruct`:
  - `typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_TURN} ram_arb_state_t;`
  - Port-index constants `PORT_FETCH` = 0 and `PORT_DATA` = 1.
- Sub-module `rr_arbiter2`: combinational pick from `req[1:0]` and `last_winner`, with a registered `last_winner` update on accept.
- The FSM, the tri-state driver and the response tag live in `ram_arbiter`.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-run → all outputs take their reset values the same cycle; `ram_data` is `'z`.
- **Single read:** preload mem[5] = 8'hA5; `req0` with `addr0` = 5 → `gnt0` the same cycle; next cycle `ram_rd_en` = 1 with `ram_addr` = 5; the cycle after, `rvalid0` = 1 and `rdata` = 8'hA5.
- **Write then read, `TURN_EN` = 1:** `req1` writes 8'h3C to addr 3, then `req0` reads addr 3 → cycles WRITE, TURN (`ram_data` = `'z`, both enables 0), READ; then `rvalid0` with `rdata` = 8'h3C.
- **Continuous reads:** `req0` and `req1` (read) both held high for 6 cycles → grants alternate 0,1,0,1,…; `ram_rd_en` stays high; no TURN; `rvalid` tags alternate correctly.
- **Reset during WRITE:** `req1` writes 8'hFF to addr 7 and `rst_n` falls during the WRITE cycle → `ram_wr_en` drops immediately; mem[7] is unchanged.
- **`TURN_EN` = 0:** a write followed by a read is granted back-to-back, with READ in the cycle directly after WRITE and no bubble.

Source files
------------

// File: rtl/InstructionStruct.sv
`default_nettype none
// ============================================================================
//  Module      : InstructionStruct (package)
//  Description : Shared widths, RAM-arbiter state encoding and port indices
//                used by the RAM arbiter and its round-robin helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package InstructionStruct;

    // Address and data widths of the single-port RAM
    localparam int AWIDTH = 8;
    localparam int DWIDTH = 8;

    // State register mirrors the access currently on the RAM pins
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_TURN} ram_arb_state_t;

    // Requester port indices
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // True when the state has the data bus committed to a direction
    function automatic logic is_busy_dir(input ram_arb_state_t st);
        return (st == ST_READ) || (st == ST_WRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-requester round-robin pick. The pick is combinational;
//                the last winner is remembered only when a transfer is
//                accepted, so a masked pick keeps its turn.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import InstructionStruct::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       pick_valid,
    output logic       pick
);

    logic r_last_winner;

    // Combinational pick: lone requester wins, a tie goes to the previous loser
    always_comb begin
        pick_valid = |req;
        case (req)
            2'b10:   pick = PORT_DATA;
            2'b11:   pick = ~r_last_winner;
            default: pick = PORT_FETCH;
        endcase
    end

    // Remember the winner of each accepted transfer; reset favours port 0 first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_winner <= PORT_DATA;
        end else if (accept) begin
            r_last_winner <= pick;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Two-port arbiter/sequencer for a single-port asynchronous-
//                read RAM with a shared tri-state data bus. Port 0 is a
//                read-only fetch port, port 1 is load/store. Inserts a TURN
//                bubble on bus direction changes and returns registered read
//                data tagged to the winning port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import InstructionStruct::*;
#(
    parameter bit TURN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    // Port 0: instruction fetch (read only)
    input  logic              req0,
    input  logic [AWIDTH-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    // Port 1: load/store
    input  logic              req1,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    // Shared read data
    output logic [DWIDTH-1:0] rdata,
    // RAM pins
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_rd_en,
    output logic              ram_wr_en,
    inout  wire  [DWIDTH-1:0] ram_data
);

    ram_arb_state_t    r_state;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic              r_rd_en;
    logic              r_wr_en;
    logic              r_tag;
    logic [DWIDTH-1:0] r_rdata;
    logic              r_rvalid0;
    logic              r_rvalid1;

    logic              w_pick_valid;
    logic              w_pick;
    logic              w_pick_write;
    logic              w_mask;
    logic              w_accept;
    logic [AWIDTH-1:0] w_addr;

    rr_arbiter2 u_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        ({req1, req0}),
        .accept     (w_accept),
        .pick_valid (w_pick_valid),
        .pick       (w_pick)
    );

    // Suppress a pick whose direction opposes the access now on the bus
    always_comb begin
        w_pick_write = (w_pick == PORT_DATA) && we1;
        w_mask       = 1'b0;
        if (TURN_EN) begin
            w_mask = ((r_state == ST_READ)  &&  w_pick_write) ||
                     ((r_state == ST_WRITE) && !w_pick_write);
        end
        w_accept = w_pick_valid && !w_mask;
        w_addr   = (w_pick == PORT_DATA) ? addr1 : addr0;
    end

    assign gnt0 = w_accept && (w_pick == PORT_FETCH);
    assign gnt1 = w_accept && (w_pick == PORT_DATA);

    // Access sequencer: launches the accepted access onto registered RAM pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_tag   <= PORT_FETCH;
        end else if (w_accept) begin
            r_state <= w_pick_write ? ST_WRITE : ST_READ;
            r_addr  <= w_addr;
            r_wdata <= wdata1;
            r_rd_en <= !w_pick_write;
            r_wr_en <= w_pick_write;
            r_tag   <= w_pick;
        end else begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            // A pending but masked request parks the bus for one bubble
            if (w_pick_valid && is_busy_dir(r_state)) begin
                r_state <= ST_TURN;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

    // Capture read data at the end of a READ cycle and pulse the tagged valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata   <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= (r_state == ST_READ) && (r_tag == PORT_FETCH);
            r_rvalid1 <= (r_state == ST_READ) && (r_tag == PORT_DATA);
            if (r_state == ST_READ) begin
                r_rdata <= ram_data;
            end
        end
    end

    assign ram_addr  = r_addr;
    assign ram_rd_en = r_rd_en;
    assign ram_wr_en = r_wr_en;
    assign ram_data  = r_wr_en ? r_wdata : {DWIDTH{1'bz}};
    assign rdata     = r_rdata;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Bench for ram_arbiter. Instance a uses the TURN bubble,
//                instance b has it disabled. Each drives its own RAM model.
//                Read responses are checked against a queue of expected
//                {port, data} entries by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
    import InstructionStruct::*;

    logic clk;
    logic rst_n;
    logic mem_init;

    // Instance a (TURN_EN = 1)
    logic              req0, req1, we1;
    logic [AWIDTH-1:0] addr0, addr1;
    logic [DWIDTH-1:0] wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DWIDTH-1:0] rdata;
    logic [AWIDTH-1:0] ram_addr;
    logic              ram_rd_en, ram_wr_en;
    wire  [DWIDTH-1:0] ram_data;

    // Instance b (TURN_EN = 0)
    logic              req0_b, req1_b, we1_b;
    logic [AWIDTH-1:0] addr0_b, addr1_b;
    logic [DWIDTH-1:0] wdata1_b;
    logic              gnt0_b, gnt1_b, rvalid0_b, rvalid1_b;
    logic [DWIDTH-1:0] rdata_b;
    logic [AWIDTH-1:0] ram_addr_b;
    logic              ram_rd_en_b, ram_wr_en_b;
    wire  [DWIDTH-1:0] ram_data_b;

    logic [DWIDTH-1:0] mem_a [256];
    logic [DWIDTH-1:0] mem_b [256];

    logic [8:0] q_a [$];
    logic [8:0] q_b [$];

    int n_tests = 0;
    int n_fail  = 0;

    ram_arbiter #(.TURN_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata(rdata),
        .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
        .ram_data(ram_data)
    );

    ram_arbiter #(.TURN_EN(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_b), .addr0(addr0_b), .gnt0(gnt0_b), .rvalid0(rvalid0_b),
        .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b),
        .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata(rdata_b),
        .ram_addr(ram_addr_b), .ram_rd_en(ram_rd_en_b), .ram_wr_en(ram_wr_en_b),
        .ram_data(ram_data_b)
    );

    // RAM models: asynchronous read onto the bus, write at posedge
    assign ram_data   = ram_rd_en   ? mem_a[ram_addr]   : {DWIDTH{1'bz}};
    assign ram_data_b = ram_rd_en_b ? mem_b[ram_addr_b] : {DWIDTH{1'bz}};

    // Memory contents start as addr ^ 8'hA0 so every location is distinct
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 8'(i) ^ 8'hA0;
                mem_b[i] <= 8'(i) ^ 8'hA0;
            end
        end else begin
            if (ram_wr_en)   mem_a[ram_addr]   <= ram_data;
            if (ram_wr_en_b) mem_b[ram_addr_b] <= ram_data_b;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor for instance a
    always @(negedge clk) begin
        if (rvalid0 || rvalid1) begin
            check("rvalid_onehot_a", 32'(rvalid0 && rvalid1), 32'(0));
            if (q_a.size() == 0) begin
                check("unexpected_rsp_a", 32'({rvalid1, rvalid0, rdata}), 32'(0));
            end else begin
                check("rsp_a", 32'({rvalid1, rvalid0, rdata}),
                      32'({q_a[0][8], ~q_a[0][8], q_a[0][7:0]}));
                void'(q_a.pop_front());
            end
        end
    end

    // Response monitor for instance b
    always @(negedge clk) begin
        if (rvalid0_b || rvalid1_b) begin
            if (q_b.size() == 0) begin
                check("unexpected_rsp_b", 32'({rvalid1_b, rvalid0_b, rdata_b}), 32'(0));
            end else begin
                check("rsp_b", 32'({rvalid1_b, rvalid0_b, rdata_b}),
                      32'({q_b[0][8], ~q_b[0][8], q_b[0][7:0]}));
                void'(q_b.pop_front());
            end
        end
    end

    initial begin
        logic exp_port;
        rst_n    = 1'b0;
        mem_init = 1'b1;
        req0 = 0; req1 = 0; we1 = 0; addr0 = '0; addr1 = '0; wdata1 = '0;
        req0_b = 0; req1_b = 0; we1_b = 0; addr0_b = '0; addr1_b = '0; wdata1_b = '0;

        tick();
        tick();
        mem_init = 1'b0;

        // Reset state
        check("rst_rd_en", 32'(ram_rd_en), 32'(0));
        check("rst_wr_en", 32'(ram_wr_en), 32'(0));
        check("rst_addr", 32'(ram_addr), 32'(0));
        check("rst_rdata", 32'(rdata), 32'(0));
        check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'(0));
        check("rst_gnt_idle", 32'({gnt1, gnt0}), 32'(0));
        rst_n = 1'b1;
        tick();

        // Single read: mem[5] = 8'hA5
        req0 = 1; addr0 = 8'd5;
        #1;
        check("single_gnt", 32'({gnt1, gnt0}), 32'(2'b01));
        q_a.push_back({PORT_FETCH, 8'hA5});
        tick();
        req0 = 0;
        check("single_rd_en", 32'(ram_rd_en), 32'(1));
        check("single_addr", 32'(ram_addr), 32'(5));
        check("single_wr_en", 32'(ram_wr_en), 32'(0));
        tick();
        check("single_rvalid0", 32'({rvalid1, rvalid0}), 32'(2'b01));
        check("single_rdata", 32'(rdata), 32'(8'hA5));
        tick();

        // Write 8'h3C to addr 3, then read addr 3 across a TURN bubble
        req1 = 1; we1 = 1; addr1 = 8'd3; wdata1 = 8'h3C;
        #1;
        check("wr_gnt", 32'({gnt1, gnt0}), 32'(2'b10));
        tick();
        req1 = 0; we1 = 0;
        req0 = 1; addr0 = 8'd3;
        #1;
        check("wr_wr_en", 32'(ram_wr_en), 32'(1));
        check("wr_addr", 32'(ram_addr), 32'(3));
        check("wr_masked_gnt0", 32'(gnt0), 32'(0));
        tick();
        check("turn_enables", 32'({ram_rd_en, ram_wr_en}), 32'(0));
        check("turn_gnt0", 32'(gnt0), 32'(1));
        check("mem3_written", 32'(mem_a[3]), 32'(8'h3C));
        q_a.push_back({PORT_FETCH, 8'h3C});
        tick();
        req0 = 0;
        check("rd_after_turn", 32'({ram_rd_en, ram_wr_en}), 32'(2'b10));
        check("rd_after_turn_addr", 32'(ram_addr), 32'(3));
        tick();
        tick();

        // Continuous reads from both ports; port 0 won last, so port 1 leads
        req0 = 1; addr0 = 8'd10;
        req1 = 1; we1 = 0; addr1 = 8'd11;
        for (int i = 0; i < 6; i++) begin
            exp_port = (i % 2 == 0) ? PORT_DATA : PORT_FETCH;
            #1;
            check("stream_gnt", 32'({gnt1, gnt0}), exp_port ? 32'(2'b10) : 32'(2'b01));
            q_a.push_back(exp_port ? {PORT_DATA, 8'hAB} : {PORT_FETCH, 8'hAA});
            if (i > 0) begin
                check("stream_rd_en", 32'({ram_rd_en, ram_wr_en}), 32'(2'b10));
            end
            tick();
        end
        req0 = 0; req1 = 0;
        check("stream_last_rd_en", 32'({ram_rd_en, ram_wr_en}), 32'(2'b10));
        tick();
        tick();

        // Reset during a READ cycle cancels the pending response
        req0 = 1; addr0 = 8'd5;
        #1;
        check("rstrd_gnt", 32'(gnt0), 32'(1));
        tick();
        req0 = 0;
        check("rstrd_rd_en", 32'(ram_rd_en), 32'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("rstrd_enables", 32'({ram_rd_en, ram_wr_en}), 32'(0));
        check("rstrd_addr", 32'(ram_addr), 32'(0));
        check("rstrd_rdata", 32'(rdata), 32'(0));
        tick();
        check("rstrd_rvalid", 32'({rvalid1, rvalid0}), 32'(0));
        rst_n = 1'b1;
        tick();

        // Reset during a WRITE cycle aborts the write
        req1 = 1; we1 = 1; addr1 = 8'd7; wdata1 = 8'hFF;
        #1;
        check("rstwr_gnt", 32'({gnt1, gnt0}), 32'(2'b10));
        tick();
        req1 = 0; we1 = 0;
        check("rstwr_wr_en", 32'(ram_wr_en), 32'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("rstwr_wr_drop", 32'(ram_wr_en), 32'(0));
        tick();
        check("rstwr_mem7", 32'(mem_a[7]), 32'(8'hA7));
        rst_n = 1'b1;
        tick();

        // TURN_EN = 0: write then read back-to-back with no bubble
        req1_b = 1; we1_b = 1; addr1_b = 8'd2; wdata1_b = 8'h77;
        #1;
        check("nt_wr_gnt", 32'({gnt1_b, gnt0_b}), 32'(2'b10));
        tick();
        req1_b = 0; we1_b = 0;
        req0_b = 1; addr0_b = 8'd2;
        #1;
        check("nt_wr_en", 32'(ram_wr_en_b), 32'(1));
        check("nt_rd_gnt", 32'(gnt0_b), 32'(1));
        q_b.push_back({PORT_FETCH, 8'h77});
        tick();
        req0_b = 0;
        check("nt_rd_next", 32'({ram_rd_en_b, ram_wr_en_b}), 32'(2'b10));
        check("nt_rd_addr", 32'(ram_addr_b), 32'(2));
        check("nt_mem2", 32'(mem_b[2]), 32'(8'h77));
        tick();
        check("nt_rvalid0", 32'({rvalid1_b, rvalid0_b}), 32'(2'b01));
        tick();
        tick();

        // Every expected response must have been seen
        check("q_a_drained", 32'(q_a.size()), 32'(0));
        check("q_b_drained", 32'(q_b.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
